// File: rtl/axi_xbar_pkg.sv
// Shared crossbar definitions: read-return state encoding, id widths and response codes.
package axi_xbar_pkg;

    localparam int ID_IN_W  = 6;
    localparam int ID_OUT_W = 4;
    localparam int NUM_SLV  = 3;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_SLV  = 2'd1,
        RD_ERR  = 2'd2
    } rd_state_e;

    function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-request round-robin arbiter: searches upward from ptr_i (wrapping) and returns a one-hot grant.
module rr_arb4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    input  logic       en_i,
    output logic [3:0] gnt_o
);

    logic [3:0] rot_s;
    logic [3:0] pick_s;

    // Rotate so ptr_i lands at bit 0, take the lowest request, rotate the pick back.
    always_comb begin
        case (ptr_i)
            2'd0:    rot_s = req_i;
            2'd1:    rot_s = {req_i[0], req_i[3:1]};
            2'd2:    rot_s = {req_i[1:0], req_i[3:2]};
            2'd3:    rot_s = {req_i[2:0], req_i[3]};
            default: rot_s = 4'b0000;
        endcase

        casez (rot_s)
            4'b???1: pick_s = 4'b0001;
            4'b??10: pick_s = 4'b0010;
            4'b?100: pick_s = 4'b0100;
            4'b1000: pick_s = 4'b1000;
            default: pick_s = 4'b0000;
        endcase

        if (en_i) begin
            case (ptr_i)
                2'd0:    gnt_o = pick_s;
                2'd1:    gnt_o = {pick_s[2:0], pick_s[3]};
                2'd2:    gnt_o = {pick_s[1:0], pick_s[3:2]};
                2'd3:    gnt_o = {pick_s[0], pick_s[3:1]};
                default: gnt_o = 4'b0000;
            endcase
        end else begin
            gnt_o = 4'b0000;
        end
    end

endmodule

// File: rtl/read_data_return_mux.sv
// Read-data return path for one master: whole-burst round-robin over slaves 0..2 and DECERR bursts.
// Defining RD_RETURN_PERF_EN adds saturating perf_bursts / perf_beats counters.
module read_data_return_mux
    import axi_xbar_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter logic [1:0]  MASTER_IDX = 2'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_IN_W-1:0]  s0_r_rid,
    input  logic [DATA_W-1:0]   s0_r_rdata,
    input  logic [1:0]          s0_r_rresp,
    input  logic                s0_r_rlast,
    input  logic                s0_r_valid,
    output logic                s0_r_ready,
    input  logic [ID_IN_W-1:0]  s1_r_rid,
    input  logic [DATA_W-1:0]   s1_r_rdata,
    input  logic [1:0]          s1_r_rresp,
    input  logic                s1_r_rlast,
    input  logic                s1_r_valid,
    output logic                s1_r_ready,
    input  logic [ID_IN_W-1:0]  s2_r_rid,
    input  logic [DATA_W-1:0]   s2_r_rdata,
    input  logic [1:0]          s2_r_rresp,
    input  logic                s2_r_rlast,
    input  logic                s2_r_valid,
    output logic                s2_r_ready,
    input  logic                inv_valid,
    input  logic [ID_OUT_W-1:0] inv_id,
    input  logic [7:0]          inv_len,
    output logic                inv_ready,
    output logic [ID_OUT_W-1:0] m_r_rid,
    output logic [DATA_W-1:0]   m_r_rdata,
    output logic [1:0]          m_r_rresp,
    output logic                m_r_rlast,
    output logic                m_r_valid,
    input  logic                m_r_ready
`ifdef RD_RETURN_PERF_EN
    ,
    output logic [15:0]         perf_bursts,
    output logic [15:0]         perf_beats
`endif
);

    logic [ID_IN_W-1:0]  s_rid_s   [NUM_SLV];
    logic [DATA_W-1:0]   s_rdata_s [NUM_SLV];
    logic [1:0]          s_rresp_s [NUM_SLV];
    logic [NUM_SLV-1:0]  s_rlast_s;
    logic [NUM_SLV-1:0]  s_valid_s;
    logic [NUM_SLV-1:0]  s_ready_s;
    logic [NUM_SLV-1:0]  s_match_s;

    rd_state_e           state_q, state_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic [7:0]          inv_len_q, inv_len_d;
    logic [ID_OUT_W-1:0] inv_id_q, inv_id_d;
    logic [3:0]          req_s;
    logic [3:0]          gnt_oh_s;
    logic                arb_en_s;

    assign s_rid_s[0]   = s0_r_rid;
    assign s_rid_s[1]   = s1_r_rid;
    assign s_rid_s[2]   = s2_r_rid;
    assign s_rdata_s[0] = s0_r_rdata;
    assign s_rdata_s[1] = s1_r_rdata;
    assign s_rdata_s[2] = s2_r_rdata;
    assign s_rresp_s[0] = s0_r_rresp;
    assign s_rresp_s[1] = s1_r_rresp;
    assign s_rresp_s[2] = s2_r_rresp;
    assign s_rlast_s    = {s2_r_rlast, s1_r_rlast, s0_r_rlast};
    assign s_valid_s    = {s2_r_valid, s1_r_valid, s0_r_valid};
    assign s0_r_ready   = s_ready_s[0];
    assign s1_r_ready   = s_ready_s[1];
    assign s2_r_ready   = s_ready_s[2];

    // A slave requests only with a beat tagged for this master in rid[5:4].
    always_comb begin
        for (int i = 0; i < NUM_SLV; i++) begin
            s_match_s[i] = s_valid_s[i] & (s_rid_s[i][ID_IN_W-1 -: 2] == MASTER_IDX);
        end
    end

    assign req_s    = {inv_valid, s_match_s};
    assign arb_en_s = (state_q == RD_IDLE);

    rr_arb4 u_arb (
        .req_i (req_s),
        .ptr_i (rr_ptr_q),
        .en_i  (arb_en_s),
        .gnt_o (gnt_oh_s)
    );

    // Next-state and output decode; the grant is held until the rlast handshake.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        inv_len_d  = inv_len_q;
        inv_id_d   = inv_id_q;
        s_ready_s  = {NUM_SLV{1'b0}};
        inv_ready  = 1'b0;
        m_r_valid  = 1'b0;
        m_r_rid    = {ID_OUT_W{1'b0}};
        m_r_rdata  = {DATA_W{1'b0}};
        m_r_rresp  = 2'b00;
        m_r_rlast  = 1'b0;

        case (state_q)
            RD_IDLE: begin
                if (gnt_oh_s[3]) begin
                    inv_ready  = 1'b1;
                    inv_id_d   = inv_id;
                    inv_len_d  = inv_len;
                    beat_cnt_d = 8'd0;
                    state_d    = RD_ERR;
                end else if (|gnt_oh_s) begin
                    gnt_d   = onehot4_to_idx(gnt_oh_s);
                    state_d = RD_SLV;
                end else begin
                    state_d = RD_IDLE;
                end
            end
            RD_SLV: begin
                m_r_valid        = s_valid_s[gnt_q];
                m_r_rid          = s_rid_s[gnt_q][ID_OUT_W-1:0];
                m_r_rdata        = s_rdata_s[gnt_q];
                m_r_rresp        = s_rresp_s[gnt_q];
                m_r_rlast        = s_rlast_s[gnt_q];
                s_ready_s[gnt_q] = m_r_ready;
                if (s_valid_s[gnt_q] && m_r_ready && s_rlast_s[gnt_q]) begin
                    rr_ptr_d = gnt_q + 2'd1;
                    state_d  = RD_IDLE;
                end else begin
                    state_d  = RD_SLV;
                end
            end
            RD_ERR: begin
                m_r_valid = 1'b1;
                m_r_rid   = inv_id_q;
                m_r_rresp = RESP_DECERR;
                m_r_rlast = (beat_cnt_q == inv_len_q);
                if (m_r_ready && m_r_rlast) begin
                    rr_ptr_d = 2'd0;
                    state_d  = RD_IDLE;
                end else if (m_r_ready) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d = RD_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RD_IDLE;
            gnt_q      <= 2'd0;
            rr_ptr_q   <= 2'd0;
            beat_cnt_q <= 8'd0;
            inv_len_q  <= 8'd0;
            inv_id_q   <= {ID_OUT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            inv_len_q  <= inv_len_d;
            inv_id_q   <= inv_id_d;
        end
    end

`ifdef RD_RETURN_PERF_EN
    logic        hs_s;
    logic [15:0] perf_bursts_q;
    logic [15:0] perf_beats_q;

    assign hs_s        = m_r_valid & m_r_ready;
    assign perf_bursts = perf_bursts_q;
    assign perf_beats  = perf_beats_q;

    // Saturating counters of master-side beats and completed bursts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bursts_q <= 16'd0;
            perf_beats_q  <= 16'd0;
        end else begin
            if (hs_s && (perf_beats_q != 16'hFFFF)) begin
                perf_beats_q <= perf_beats_q + 16'd1;
            end else begin
                perf_beats_q <= perf_beats_q;
            end
            if (hs_s && m_r_rlast && (perf_bursts_q != 16'hFFFF)) begin
                perf_bursts_q <= perf_bursts_q + 16'd1;
            end else begin
                perf_bursts_q <= perf_bursts_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_read_data_return_mux.sv
// Self-checking bench for read_data_return_mux (MASTER_IDX=0): directed vector table, directed bursts,
// randomized traffic against a burst-level arbitration model, and reset mid-burst.
module tb_read_data_return_mux;

    typedef struct packed {
        logic        mv;
        logic [3:0]  rid;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [2:0]  sready;
        logic        invr;
    } out_t;

    typedef struct packed {
        logic       inv_v;
        logic [3:0] inv_id;
        logic [7:0] inv_len;
        logic [2:0] sv;
        logic [5:0] srid;
        logic       slast;
        logic       mrdy;
        out_t       exp;
    } vec_t;

    typedef struct packed {
        logic [5:0]  rid;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] len;
    } inv_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  b_rid  [3];
    logic [31:0] b_data [3];
    logic [1:0]  b_resp [3];
    logic [2:0]  b_last;
    logic [2:0]  b_valid;
    wire  [2:0]  b_ready;
    logic        inv_valid;
    logic [3:0]  inv_id;
    logic [7:0]  inv_len;
    logic        inv_ready;
    logic [3:0]  m_r_rid;
    logic [31:0] m_r_rdata;
    logic [1:0]  m_r_rresp;
    logic        m_r_rlast;
    logic        m_r_valid;
    logic        m_r_ready;
`ifdef RD_RETURN_PERF_EN
    logic [15:0] perf_bursts;
    logic [15:0] perf_beats;
`endif

    int checks = 0;
    int errors = 0;

    beat_t sq [3][$];
    inv_t  iq [$];

    // Reference model state: current burst owner (-1 none, 3 = DECERR), rr pointer, DECERR progress.
    int         owner = -1;
    int         ptr = 0;
    int         err_beat = 0;
    logic [3:0] err_id = 4'h0;
    logic [7:0] err_len = 8'h00;

    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'h2222_2222;
    localparam logic [31:0] D2 = 32'h3333_3333;

    always #5 clk = ~clk;

    read_data_return_mux #(.DATA_W(32), .MASTER_IDX(2'd0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s0_r_rid   (b_rid[0]),
        .s0_r_rdata (b_data[0]),
        .s0_r_rresp (b_resp[0]),
        .s0_r_rlast (b_last[0]),
        .s0_r_valid (b_valid[0]),
        .s0_r_ready (b_ready[0]),
        .s1_r_rid   (b_rid[1]),
        .s1_r_rdata (b_data[1]),
        .s1_r_rresp (b_resp[1]),
        .s1_r_rlast (b_last[1]),
        .s1_r_valid (b_valid[1]),
        .s1_r_ready (b_ready[1]),
        .s2_r_rid   (b_rid[2]),
        .s2_r_rdata (b_data[2]),
        .s2_r_rresp (b_resp[2]),
        .s2_r_rlast (b_last[2]),
        .s2_r_valid (b_valid[2]),
        .s2_r_ready (b_ready[2]),
        .inv_valid  (inv_valid),
        .inv_id     (inv_id),
        .inv_len    (inv_len),
        .inv_ready  (inv_ready),
        .m_r_rid    (m_r_rid),
        .m_r_rdata  (m_r_rdata),
        .m_r_rresp  (m_r_rresp),
        .m_r_rlast  (m_r_rlast),
        .m_r_valid  (m_r_valid),
        .m_r_ready  (m_r_ready)
`ifdef RD_RETURN_PERF_EN
        ,
        .perf_bursts(perf_bursts),
        .perf_beats (perf_beats)
`endif
    );

    function automatic out_t o(input logic mv, input logic [3:0] rid, input logic [31:0] data,
                               input logic [1:0] resp, input logic last, input logic [2:0] sr,
                               input logic ir);
        out_t r;
        r.mv = mv; r.rid = rid; r.data = data; r.resp = resp;
        r.last = last; r.sready = sr; r.invr = ir;
        return r;
    endfunction

    function automatic vec_t mk(input logic iv, input logic [3:0] iid, input logic [7:0] ilen,
                                input logic [2:0] sv, input logic [5:0] srid, input logic sl,
                                input logic mr, input out_t e);
        vec_t v;
        v.inv_v = iv; v.inv_id = iid; v.inv_len = ilen; v.sv = sv;
        v.srid = srid; v.slast = sl; v.mrdy = mr; v.exp = e;
        return v;
    endfunction

    function automatic out_t sample();
        return o(m_r_valid, m_r_rid, m_r_rdata, m_r_rresp, m_r_rlast, b_ready, inv_ready);
    endfunction

    function automatic int rr_pick(input logic [3:0] req, input int p);
        for (int k = 0; k < 4; k++) begin
            if (req[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: actual v=%b id=%h d=%h resp=%b last=%b srdy=%b invr=%b required v=%b id=%h d=%h resp=%b last=%b srdy=%b invr=%b",
                     name, $time, act.mv, act.rid, act.data, act.resp, act.last, act.sready, act.invr,
                     exp.mv, exp.rid, exp.data, exp.resp, exp.last, exp.sready, exp.invr);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_burst(input int s, input logic [3:0] id, input int n);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            bt.rid  = {2'b00, id};
            bt.data = $urandom;
            bt.resp = 2'($urandom_range(3));
            bt.last = (b == n - 1);
            sq[s].push_back(bt);
        end
    endtask

    // rdy_mode: 0 = always ready, 1 = random, 2 = toggling. gaps: slaves randomly drop valid.
    task automatic run_engine(input string tag, input int max_cyc, input int rdy_mode,
                              input bit gaps, input int exp_beats);
        int         cyc;
        int         beats;
        int         win;
        bit         done;
        bit         hs;
        logic [3:0] req;
        out_t       e;
        cyc = 0; beats = 0; done = 1'b0;
        while (!done && cyc < max_cyc) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (sq[i].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
                    b_valid[i] = 1'b1;
                    {b_rid[i], b_data[i], b_resp[i], b_last[i]} = sq[i][0];
                end else begin
                    b_valid[i] = 1'b0;
                    b_rid[i]   = 6'($urandom);
                    b_data[i]  = $urandom;
                    b_resp[i]  = 2'($urandom);
                    b_last[i]  = 1'($urandom);
                end
            end
            inv_valid = (iq.size() > 0);
            if (iq.size() > 0) {inv_id, inv_len} = iq[0];
            else {inv_id, inv_len} = 12'($urandom);
            m_r_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(1)) : 1'(cyc % 2);
            #1;
            e = '0;
            win = -1;
            for (int i = 0; i < 3; i++) req[i] = b_valid[i] && (b_rid[i][5:4] == 2'b00);
            req[3] = inv_valid;
            if (owner < 0) begin
                win = rr_pick(req, ptr);
                e.invr = (win == 3);
            end else if (owner < 3) begin
                e.mv   = b_valid[owner];
                e.rid  = b_rid[owner][3:0];
                e.data = b_data[owner];
                e.resp = b_resp[owner];
                e.last = b_last[owner];
                e.sready[owner] = m_r_ready;
            end else begin
                e.mv   = 1'b1;
                e.rid  = err_id;
                e.resp = 2'b11;
                e.last = (err_beat == int'(err_len));
            end
            check(tag, sample(), e);
            hs = e.mv && m_r_ready;
            if (owner < 0) begin
                if (win >= 0) begin
                    owner = win;
                    if (win == 3) begin
                        err_id = inv_id; err_len = inv_len; err_beat = 0;
                    end
                end
            end else if (hs && e.last) begin
                ptr   = (owner == 3) ? 0 : (owner + 1) % 4;
                owner = -1;
            end else if (hs && owner == 3) begin
                err_beat++;
            end
            for (int i = 0; i < 3; i++) begin
                if (b_valid[i] && b_ready[i] && sq[i].size() > 0) void'(sq[i].pop_front());
            end
            if (inv_valid && inv_ready && iq.size() > 0) void'(iq.pop_front());
            if (m_r_valid && m_r_ready) beats++;
            cyc++;
            done = (sq[0].size() == 0) && (sq[1].size() == 0) && (sq[2].size() == 0) &&
                   (iq.size() == 0) && (owner < 0);
        end
        check_int({tag, "_completed"}, int'(done), 1);
        check_int({tag, "_beats"}, beats, exp_beats);
    endtask

    task automatic idle_inputs();
        b_valid = 3'b000; b_last = 3'b000; inv_valid = 1'b0; inv_id = 4'h0; inv_len = 8'h00;
        m_r_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_rid[i] = 6'h00; b_data[i] = 32'h0; b_resp[i] = 2'b00;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [19];
        int   total;
        int   n;
        inv_t iv;

        tbl[0]  = mk(1'b0, 4'h0, 8'd0, 3'b010, 6'h07, 1'b0, 1'b1, o(1'b0, 4'h0, 32'h0, 2'd0, 1'b0, 3'b000, 1'b0));
        tbl[1]  = mk(1'b0, 4'h0, 8'd0, 3'b010, 6'h07, 1'b0, 1'b1, o(1'b1, 4'h7, D1, 2'd1, 1'b0, 3'b010, 1'b0));
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = mk(1'b0, 4'h0, 8'd0, 3'b010, 6'h07, 1'b1, 1'b1, o(1'b1, 4'h7, D1, 2'd1, 1'b1, 3'b010, 1'b0));
        tbl[5]  = mk(1'b1, 4'hA, 8'd2, 3'b000, 6'h07, 1'b0, 1'b1, o(1'b0, 4'h0, 32'h0, 2'd0, 1'b0, 3'b000, 1'b1));
        tbl[6]  = mk(1'b0, 4'h0, 8'd0, 3'b000, 6'h07, 1'b0, 1'b1, o(1'b1, 4'hA, 32'h0, 2'd3, 1'b0, 3'b000, 1'b0));
        tbl[7]  = mk(1'b0, 4'h0, 8'd0, 3'b000, 6'h07, 1'b0, 1'b0, o(1'b1, 4'hA, 32'h0, 2'd3, 1'b0, 3'b000, 1'b0));
        tbl[8]  = tbl[6];
        tbl[9]  = mk(1'b0, 4'h0, 8'd0, 3'b000, 6'h07, 1'b0, 1'b1, o(1'b1, 4'hA, 32'h0, 2'd3, 1'b1, 3'b000, 1'b0));
        tbl[10] = mk(1'b0, 4'h0, 8'd0, 3'b101, 6'h00, 1'b1, 1'b1, o(1'b0, 4'h0, 32'h0, 2'd0, 1'b0, 3'b000, 1'b0));
        tbl[11] = mk(1'b0, 4'h0, 8'd0, 3'b101, 6'h00, 1'b1, 1'b1, o(1'b1, 4'h0, D0, 2'd0, 1'b1, 3'b001, 1'b0));
        tbl[12] = mk(1'b0, 4'h0, 8'd0, 3'b100, 6'h00, 1'b1, 1'b1, o(1'b0, 4'h0, 32'h0, 2'd0, 1'b0, 3'b000, 1'b0));
        tbl[13] = mk(1'b0, 4'h0, 8'd0, 3'b100, 6'h00, 1'b1, 1'b1, o(1'b1, 4'h0, D2, 2'd2, 1'b1, 3'b100, 1'b0));
        tbl[14] = mk(1'b0, 4'h0, 8'd0, 3'b001, 6'h15, 1'b0, 1'b1, o(1'b0, 4'h0, 32'h0, 2'd0, 1'b0, 3'b000, 1'b0));
        tbl[15] = tbl[14];
        tbl[16] = mk(1'b1, 4'h3, 8'd0, 3'b000, 6'h15, 1'b0, 1'b1, o(1'b0, 4'h0, 32'h0, 2'd0, 1'b0, 3'b000, 1'b1));
        tbl[17] = mk(1'b0, 4'h0, 8'd0, 3'b000, 6'h15, 1'b0, 1'b1, o(1'b1, 4'h3, 32'h0, 2'd3, 1'b1, 3'b000, 1'b0));
        tbl[18] = mk(1'b0, 4'h0, 8'd0, 3'b000, 6'h15, 1'b0, 1'b1, o(1'b0, 4'h0, 32'h0, 2'd0, 1'b0, 3'b000, 1'b0));

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("reset_outputs", sample(), '0);
        rst_n = 1'b1;

        // Directed cycle table: s1 4-beat burst, DECERR len 2, s0/s2 contention, foreign tag, len 0.
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            inv_valid = tbl[i].inv_v;
            inv_id    = tbl[i].inv_id;
            inv_len   = tbl[i].inv_len;
            b_valid   = tbl[i].sv;
            b_last    = {3{tbl[i].slast}};
            m_r_ready = tbl[i].mrdy;
            b_data[0] = D0; b_data[1] = D1; b_data[2] = D2;
            for (int s = 0; s < 3; s++) begin
                b_rid[s]  = tbl[i].srid;
                b_resp[s] = 2'(s);
            end
            #1;
            check($sformatf("vec%0d", i), sample(), tbl[i].exp);
        end
        owner = -1; ptr = 0;

        // s0 and s2 arrive together with the pointer at 0: s0 burst first, then s2.
        push_burst(0, 4'h1, 3);
        push_burst(2, 4'h2, 2);
        run_engine("contend", 100, 0, 1'b0, 5);

        // Master ready toggling through an 8-beat s2 burst.
        push_burst(2, 4'h9, 8);
        run_engine("toggle", 100, 2, 1'b0, 8);

        // Slave drops valid mid-burst; grant held.
        push_burst(1, 4'h4, 5);
        run_engine("gaps", 200, 1, 1'b1, 5);

        // Randomized mixed traffic.
        for (int r = 0; r < 20; r++) begin
            total = 0;
            for (int s = 0; s < 3; s++) begin
                for (int b = 0; b < int'($urandom_range(2)); b++) begin
                    n = $urandom_range(1, 4);
                    push_burst(s, 4'($urandom), n);
                    total += n;
                end
            end
            if ($urandom_range(1) == 1) begin
                iv.id  = 4'($urandom);
                iv.len = 8'($urandom_range(3));
                iq.push_back(iv);
                total += int'(iv.len) + 1;
            end
            run_engine($sformatf("rand%0d", r), 400, 1, 1'b1, total);
        end

        // Reset asserted on beat 2 of a DECERR burst.
        @(negedge clk);
        idle_inputs();
        inv_valid = 1'b1; inv_id = 4'h5; inv_len = 8'd3;
        #1 check("rst_seq_accept", sample(), o(1'b0, 4'h0, 32'h0, 2'd0, 1'b0, 3'b000, 1'b1));
        @(negedge clk);
        inv_valid = 1'b0;
        #1 check("rst_seq_beat0", sample(), o(1'b1, 4'h5, 32'h0, 2'd3, 1'b0, 3'b000, 1'b0));
        @(negedge clk);
        #1 check("rst_seq_beat1", sample(), o(1'b1, 4'h5, 32'h0, 2'd3, 1'b0, 3'b000, 1'b0));
        @(negedge clk);
        #1 check("rst_seq_beat2", sample(), o(1'b1, 4'h5, 32'h0, 2'd3, 1'b0, 3'b000, 1'b0));
        rst_n = 1'b0;
        #1 check("rst_mid_burst", sample(), '0);
        @(negedge clk);
        check("rst_held", sample(), '0);
`ifdef RD_RETURN_PERF_EN
        check_int("perf_beats_reset", int'(perf_beats), 0);
`endif
        rst_n = 1'b1;
        owner = -1; ptr = 0; err_beat = 0;
        iv.id = 4'h6; iv.len = 8'd1;
        iq.push_back(iv);
        run_engine("after_rst", 50, 0, 1'b0, 2);
        @(negedge clk);
`ifdef RD_RETURN_PERF_EN
        check_int("perf_beats", int'(perf_beats), 2);
        check_int("perf_bursts", int'(perf_bursts), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
